formant_dp_row: RTL and testbench

Pipelined min-plus dynamic-programming row engine for formant tracking. For one frame index i it computes every F(k,i) = min over j of E(j+1,i) + F(k-1,j), with back-pointer B(k,i) = argmin j, for k = 1..min(FORMANTS, i+1). It sits between the Emin table and the F/B tables. Rows issue back-to-back with no inter-row bubble. Memory read latency is parameterised, and addition saturates.

---
 rtl/formant_dp_pkg.sv | 27 ++
 rtl/formant_dp_row_minplus_acc.sv | 89 ++++++++
 rtl/formant_dp_row.sv | 177 +++++++++++++++++
 tb/tb_formant_dp_row.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/formant_dp_pkg.sv
// Shared types and constants for the formant min-plus DP row engine:
// INF helper, control-state enum and the tag carried alongside each read request.
package formant_dp_pkg;

    localparam int TAG_KW = 8;
    localparam int TAG_JW = 16;

    // Largest finite-looking cost; any path through it is treated as unreachable.
    function automatic logic [63:0] fdp_inf(input int bw);
        return (64'd1 << (bw - 1)) - 64'd1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } fdp_state_t;

    typedef struct packed {
        logic                     valid;
        logic                     first;
        logic                     last;
        logic [TAG_KW-1:0]        k;
        logic signed [TAG_JW-1:0] j;
    } fdp_tag_t;

endpackage

// File: rtl/formant_dp_row_minplus_acc.sv
// Saturating E+F adder followed by a running-minimum accumulator for one DP row;
// registers the row result on the row's last returning beat.
module minplus_acc
    import formant_dp_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int JW        = 9,
    parameter bit TIE_LAST  = 1'b0
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 clr_sat,
    input  logic                 beat_valid,
    input  logic                 beat_first,
    input  logic                 beat_last,
    input  logic                 beat_use_f,
    input  logic signed [JW-1:0] beat_j,
    input  logic [BIT_WIDTH-1:0] e_in,
    input  logic [BIT_WIDTH-1:0] f_in,
    output logic                 wr_valid,
    output logic [BIT_WIDTH-1:0] wr_f,
    output logic signed [JW-1:0] wr_b,
    output logic                 sat
);

    localparam logic [BIT_WIDTH-1:0] INF = BIT_WIDTH'(fdp_inf(BIT_WIDTH));

    logic [BIT_WIDTH:0]   sum;
    logic [BIT_WIDTH-1:0] cand;
    logic [BIT_WIDTH-1:0] acc_f;
    logic [BIT_WIDTH-1:0] base_f;
    logic [BIT_WIDTH-1:0] nxt_f;
    logic signed [JW-1:0] acc_b;
    logic signed [JW-1:0] base_b;
    logic signed [JW-1:0] nxt_b;
    logic                 cand_inf;
    logic                 cand_sat;
    logic                 take;

    // An INF operand propagates as INF without counting as a saturation event.
    always_comb begin
        sum      = {1'b0, e_in} + (beat_use_f ? {1'b0, f_in} : '0);
        cand_inf = (e_in == INF) || (beat_use_f && (f_in == INF));
        cand_sat = 1'b0;
        cand     = sum[BIT_WIDTH-1:0];
        if (cand_inf) begin
            cand = INF;
        end else if (sum > {1'b0, INF}) begin
            cand     = INF;
            cand_sat = 1'b1;
        end
        base_f = beat_first ? INF : acc_f;
        base_b = beat_first ? '0 : acc_b;
        if (TIE_LAST) begin
            take = (cand <= base_f) && (cand != INF);
        end else begin
            take = cand < base_f;
        end
        nxt_f = take ? cand : base_f;
        nxt_b = take ? beat_j : base_b;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_f    <= '0;
            acc_b    <= '0;
            wr_valid <= 1'b0;
            wr_f     <= '0;
            wr_b     <= '0;
            sat      <= 1'b0;
        end else begin
            wr_valid <= beat_valid && beat_last;
            if (beat_valid) begin
                acc_f <= nxt_f;
                acc_b <= nxt_b;
                if (beat_last) begin
                    wr_f <= nxt_f;
                    wr_b <= nxt_b;
                end
            end
            if (clr_sat) begin
                sat <= 1'b0;
            end else if (beat_valid && cand_sat) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/formant_dp_row.sv
// Min-plus DP row engine: sweeps all (k, j) reads for frame i back-to-back and writes F(k,i)/B(k,i).
// Define FDP_TIE_LAST_EN to resolve equal-cost ties toward the largest j.
module formant_dp_row
    import formant_dp_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int I          = 160,
    parameter int FORMANTS   = 5,
    parameter int RD_LATENCY = 2
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic                                start_in,
    input  logic [$clog2(I)-1:0]                i_in,
    output logic                                busy_out,
    output logic                                req_valid_out,
    output logic [$clog2(FORMANTS+1)-1:0]       k_req_out,
    output logic signed [$clog2(I):0]           j_req_out,
    input  logic [BIT_WIDTH-1:0]                e_in,
    input  logic [BIT_WIDTH-1:0]                f_in,
    output logic                                wr_valid_out,
    output logic [$clog2(FORMANTS+1)-1:0]       k_wr_out,
    output logic [BIT_WIDTH-1:0]                f_wr_out,
    output logic signed [$clog2(I):0]           b_wr_out,
    output logic                                done_out,
    output logic                                sat_out
);

    localparam int IW = $clog2(I);
    localparam int KW = $clog2(FORMANTS + 1);
    localparam int JW = IW + 1;
    localparam logic signed [JW-1:0] J_ONE = 1;

`ifdef FDP_TIE_LAST_EN
    localparam bit TIE_LAST = 1'b1;
`else
    localparam bit TIE_LAST = 1'b0;
`endif

    fdp_state_t           state;
    fdp_state_t           state_nxt;
    logic [IW-1:0]        i_reg;
    logic [KW-1:0]        kmax;
    logic [KW-1:0]        kmax_nxt;
    logic [KW-1:0]        k_cnt;
    logic signed [JW-1:0] j_cnt;
    logic signed [JW-1:0] i_m1;
    logic                 row_first;
    logic                 row_last;
    logic                 sweep_last;
    logic                 start_acc;
    int                   kmax_calc;
    fdp_tag_t             issue_tag;
    fdp_tag_t             pipe [RD_LATENCY];
    fdp_tag_t             tag_out;
    logic                 tag_unused;

    assign start_acc  = (state == IDLE) && start_in;
    assign i_m1       = $signed({1'b0, i_reg}) - J_ONE;
    assign row_last   = (k_cnt == KW'(1)) || (j_cnt == i_m1);
    assign sweep_last = row_last && (k_cnt == kmax);
    assign k_req_out  = k_cnt;
    assign j_req_out  = j_cnt;
    assign tag_out    = pipe[RD_LATENCY-1];
    assign tag_unused = ^tag_out.j[TAG_JW-1:JW];

    always_comb begin
        kmax_calc = int'(i_in) + 1;
        if (kmax_calc > FORMANTS) begin
            kmax_calc = FORMANTS;
        end
        kmax_nxt = KW'(kmax_calc);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy_out      = (state != IDLE);
        req_valid_out = (state == ISSUE);
        case (state)
            IDLE:    if (start_in)   state_nxt = ISSUE;
            ISSUE:   if (sweep_last) state_nxt = DRAIN;
            DRAIN:   if (done_out)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request walker: row k=1 is the single j=-1 read, row k>1 starts at j=k-2.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            i_reg     <= '0;
            kmax      <= '0;
            k_cnt     <= '0;
            j_cnt     <= '0;
            row_first <= 1'b0;
        end else if (start_acc) begin
            i_reg     <= i_in;
            kmax      <= kmax_nxt;
            k_cnt     <= KW'(1);
            j_cnt     <= -J_ONE;
            row_first <= 1'b1;
        end else if (state == ISSUE) begin
            if (row_last) begin
                k_cnt     <= k_cnt + KW'(1);
                j_cnt     <= $signed(JW'(k_cnt)) - J_ONE;
                row_first <= 1'b1;
            end else begin
                j_cnt     <= j_cnt + J_ONE;
                row_first <= 1'b0;
            end
        end
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = req_valid_out;
        issue_tag.first = row_first;
        issue_tag.last  = row_last;
        issue_tag.k     = TAG_KW'(k_cnt);
        issue_tag.j     = TAG_JW'(j_cnt);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[0] <= issue_tag;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    // Row index and sweep-complete flag line up with the accumulator's write register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            done_out <= 1'b0;
            k_wr_out <= '0;
        end else begin
            done_out <= tag_out.valid && tag_out.last && (tag_out.k == TAG_KW'(kmax));
            if (tag_out.valid && tag_out.last) begin
                k_wr_out <= KW'(tag_out.k);
            end
        end
    end

    minplus_acc #(
        .BIT_WIDTH (BIT_WIDTH),
        .JW        (JW),
        .TIE_LAST  (TIE_LAST)
    ) u_acc (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .clr_sat    (start_acc),
        .beat_valid (tag_out.valid),
        .beat_first (tag_out.first),
        .beat_last  (tag_out.last),
        .beat_use_f (tag_out.k != TAG_KW'(1)),
        .beat_j     (JW'(tag_out.j)),
        .e_in       (e_in),
        .f_in       (f_in),
        .wr_valid   (wr_valid_out),
        .wr_f       (f_wr_out),
        .wr_b       (b_wr_out),
        .sat        (sat_out)
    );

endmodule

// File: tb/tb_formant_dp_row.sv
// Scoreboard bench for formant_dp_row: directed rows on a RD_LATENCY=2 and a RD_LATENCY=4 instance,
// with a latency-accurate reader model feeding e_in/f_in.
module tb_formant_dp_row;

    localparam int BW = 32;
    localparam int NI = 160;
    localparam int NF = 5;
    localparam int IW = 8;
    localparam int KW = 3;
    localparam int JW = 9;
    localparam logic [BW-1:0] INF = 32'h7FFF_FFFF;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                 rst_n_in;
    logic                 start_in  [2];
    logic [IW-1:0]        i_in      [2];
    logic                 busy      [2];
    logic                 req_valid [2];
    logic [KW-1:0]        k_req     [2];
    logic signed [JW-1:0] j_req     [2];
    logic [BW-1:0]        e_in      [2];
    logic [BW-1:0]        f_in      [2];
    logic                 wr_valid  [2];
    logic [KW-1:0]        k_wr      [2];
    logic [BW-1:0]        f_wr      [2];
    logic signed [JW-1:0] b_wr      [2];
    logic                 done      [2];
    logic                 sat       [2];

    formant_dp_row #(.BIT_WIDTH(BW), .I(NI), .FORMANTS(NF), .RD_LATENCY(2)) dut2 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in[0]), .i_in(i_in[0]),
        .busy_out(busy[0]), .req_valid_out(req_valid[0]), .k_req_out(k_req[0]), .j_req_out(j_req[0]),
        .e_in(e_in[0]), .f_in(f_in[0]), .wr_valid_out(wr_valid[0]), .k_wr_out(k_wr[0]),
        .f_wr_out(f_wr[0]), .b_wr_out(b_wr[0]), .done_out(done[0]), .sat_out(sat[0])
    );

    formant_dp_row #(.BIT_WIDTH(BW), .I(NI), .FORMANTS(NF), .RD_LATENCY(4)) dut4 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in[1]), .i_in(i_in[1]),
        .busy_out(busy[1]), .req_valid_out(req_valid[1]), .k_req_out(k_req[1]), .j_req_out(j_req[1]),
        .e_in(e_in[1]), .f_in(f_in[1]), .wr_valid_out(wr_valid[1]), .k_wr_out(k_wr[1]),
        .f_wr_out(f_wr[1]), .b_wr_out(b_wr[1]), .done_out(done[1]), .sat_out(sat[1])
    );

    typedef struct {
        int          dut;
        int          k;
        logic [BW-1:0] f;
        int          b;
        logic        done;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mode = 0;
    int   start_cyc [2];
    int   req_cnt   [2];
    logic sh_v [2][5];
    int   sh_k [2][5];
    int   sh_j [2][5];

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic void gen_data(input int k, input int j, output logic [BW-1:0] e, output logic [BW-1:0] f);
        e = '0;
        f = '0;
        case (mode)
            0: e = 32'd7;
            1: begin e = BW'(j + 5); f = 32'd10; end
            2: begin e = BW'(j + 5); f = INF; end
            3: begin e = INF - 32'd1; f = 32'd5; end
            4: begin e = 32'd10; f = (j == 0) ? 32'd50 : 32'd10; end
            default: e = '0;
        endcase
        if (k == 1) f = 32'hDEAD_BEEF;
    endfunction

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reader model: a request seen in cycle c is answered with data that is valid only
    // across the edge ending cycle c+latency.
    always @(negedge clk_in) begin
        for (int d = 0; d < 2; d++) begin
            int lat;
            logic [BW-1:0] e;
            logic [BW-1:0] f;
            lat = (d == 0) ? 2 : 4;
            if (!rst_n_in) begin
                for (int m = 0; m < 5; m++) begin
                    sh_v[d][m] = 1'b0; sh_k[d][m] = 0; sh_j[d][m] = 0;
                end
                e_in[d] = '0;
                f_in[d] = '0;
            end else begin
                for (int m = 4; m > 0; m--) begin
                    sh_v[d][m] = sh_v[d][m-1]; sh_k[d][m] = sh_k[d][m-1]; sh_j[d][m] = sh_j[d][m-1];
                end
                sh_v[d][0] = req_valid[d];
                sh_k[d][0] = int'(k_req[d]);
                sh_j[d][0] = int'(j_req[d]);
                if (req_valid[d]) req_cnt[d]++;
                if (sh_v[d][lat]) begin
                    gen_data(sh_k[d][lat], sh_j[d][lat], e, f);
                end else begin
                    e = '0;
                    f = '0;
                end
                e_in[d] = e;
                f_in[d] = f;
            end
        end
    end

    // Monitor: every write strobe pops and checks the oldest expectation.
    always @(negedge clk_in) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n_in && wr_valid[d]) begin
                if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: dut %0d got k=%0d f=%0d b=%0d expected no write", d, k_wr[d], f_wr[d], b_wr[d]);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check_output("wr_k", longint'(k_wr[d]), x.k);
                    check_output("wr_f", longint'(f_wr[d]), longint'(x.f));
                    check_output("wr_b", longint'(int'(b_wr[d])), x.b);
                    check_output("wr_done", longint'(done[d]), longint'(x.done));
                    check_output("wr_cycle", cyc - start_cyc[d], x.cyc);
                end
            end else if (rst_n_in && done[d]) begin
                check_output("done_without_write", 1, 0);
            end
        end
    end

    task automatic expect_write(input int d, input int k, input logic [BW-1:0] f, input int b, input logic dn, input int c);
        exp_t x;
        x.dut = d; x.k = k; x.f = f; x.b = b; x.done = dn; x.cyc = c;
        exp_q.push_back(x);
    endtask

    task automatic apply_stimulus(input int d, input int mode_v, input int i_v);
        @(negedge clk_in);
        mode         = mode_v;
        start_in[d]  = 1'b1;
        i_in[d]      = IW'(i_v);
        start_cyc[d] = cyc;
        req_cnt[d]   = 0;
        @(negedge clk_in);
        start_in[d]  = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        int n;
        n = 0;
        while ((busy[d] || exp_q.size() != 0) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check_output("sweep_finished_in_budget", longint'(n < budget), 1);
        check_output("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk_in);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n_in = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_in[d] = 1'b0; i_in[d] = '0; start_cyc[d] = 0; req_cnt[d] = 0;
        end
        repeat (3) @(negedge clk_in);
        check_output("reset_busy", longint'(busy[0]), 0);
        check_output("reset_req_valid", longint'(req_valid[0]), 0);
        check_output("reset_wr_valid", longint'(wr_valid[0]), 0);
        check_output("reset_done_sat", longint'({done[0], sat[0]}), 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // i=0: single k=1 row
        expect_write(0, 1, 32'd7, -1, 1'b1, 4);
        apply_stimulus(0, 0, 0);
        check_output("i0_req_valid_c1", longint'(req_valid[0]), 1);
        check_output("i0_busy_c1", longint'(busy[0]), 1);
        check_output("i0_k_req", longint'(k_req[0]), 1);
        check_output("i0_j_req", longint'(int'(j_req[0])), -1);
        @(negedge clk_in);
        check_output("i0_req_valid_c2", longint'(req_valid[0]), 0);
        wait_idle(0, 50);
        check_output("i0_req_count", req_cnt[0], 1);

        // i=3, f=10, e=j+5
        expect_write(0, 1, 32'd4, -1, 1'b0, 4);
        expect_write(0, 2, 32'd15, 0, 1'b0, 7);
        expect_write(0, 3, 32'd16, 1, 1'b0, 9);
        expect_write(0, 4, 32'd17, 2, 1'b1, 10);
        apply_stimulus(0, 1, 3);
        wait_idle(0, 50);
        check_output("i3_req_count", req_cnt[0], 7);

        // i=3, every F(k-1,j)=INF
        expect_write(0, 1, 32'd4, -1, 1'b0, 4);
        expect_write(0, 2, INF, 0, 1'b0, 7);
        expect_write(0, 3, INF, 0, 1'b0, 9);
        expect_write(0, 4, INF, 0, 1'b1, 10);
        apply_stimulus(0, 2, 3);
        wait_idle(0, 50);
        check_output("inf_sat_clear", longint'(sat[0]), 0);

        // saturation: e=INF-1, f=5
        expect_write(0, 1, INF - 32'd1, -1, 1'b0, 4);
        expect_write(0, 2, INF, 0, 1'b1, 5);
        apply_stimulus(0, 3, 1);
        wait_idle(0, 50);
        check_output("sat_sticky", longint'(sat[0]), 1);

        // ties at cost 20 on j=1 and j=2
`ifdef FDP_TIE_LAST_EN
        expect_write(0, 1, 32'd10, -1, 1'b0, 4);
        expect_write(0, 2, 32'd20, 2, 1'b0, 7);
        expect_write(0, 3, 32'd20, 2, 1'b0, 9);
        expect_write(0, 4, 32'd20, 2, 1'b1, 10);
`else
        expect_write(0, 1, 32'd10, -1, 1'b0, 4);
        expect_write(0, 2, 32'd20, 1, 1'b0, 7);
        expect_write(0, 3, 32'd20, 1, 1'b0, 9);
        expect_write(0, 4, 32'd20, 2, 1'b1, 10);
`endif
        apply_stimulus(0, 4, 3);
        check_output("sat_cleared_on_start", longint'(sat[0]), 0);
        wait_idle(0, 50);

        // mid-row reset on the latency-4 instance
        expect_write(1, 1, 32'd4, -1, 1'b0, 6);
        apply_stimulus(1, 1, 100);
        repeat (20) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check_output("midreset_busy", longint'(busy[1]), 0);
        check_output("midreset_req", longint'({req_valid[1], k_req[1], j_req[1]}), 0);
        check_output("midreset_wr", longint'({wr_valid[1], done[1], sat[1]}), 0);
        check_output("midreset_data", longint'({f_wr[1], b_wr[1], k_wr[1]}), 0);
        check_output("midreset_k1_written", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        expect_write(1, 1, 32'd4, -1, 1'b0, 6);
        expect_write(1, 2, 32'd15, 0, 1'b1, 7);
        apply_stimulus(1, 1, 1);
        wait_idle(1, 60);
        check_output("lat4_req_count", req_cnt[1], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
